clint_timer: RTL

//  Parametrised machine-timer / software-interrupt controller (CLINT style) for 1..8 harts.

---
 rtl/clint_pkg.sv | 56 +++++
 rtl/clint_cmp_chan.sv | 51 +++++
 rtl/clint_timer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared address map, register-select decode and limits for the CLINT timer block.
// Everything address-related lives here so the top and any bus adapters agree on one map.
package clint_pkg;

   localparam int MAX_HARTS = 8;
   localparam int HART_W    = 3;

   localparam logic [15:0] MSIP_BASE     = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] PRESC_ADDR    = 16'hBFF0;
   localparam logic [15:0] MTIME_LO_ADDR = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_ADDR = 16'hBFFC;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_MSIP,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_PRESC,
      SEL_MTIME_LO,
      SEL_MTIME_HI
   } reg_sel_e;

   typedef struct packed {
      reg_sel_e            sel;
      logic [HART_W-1:0]   hart;
   } reg_dec_t;

   // Harts at or beyond num_harts, and non-word-aligned offsets, decode as SEL_NONE.
   function automatic reg_dec_t decode_addr(input logic [15:0] addr, input int num_harts);
      reg_dec_t    d;
      logic [15:0] msip_off;
      logic [15:0] cmp_off;
      msip_off = addr - MSIP_BASE;
      cmp_off  = addr - MTIMECMP_BASE;
      d.sel    = SEL_NONE;
      d.hart   = '0;
      if (addr[1:0] != 2'b00) begin
         d.sel = SEL_NONE;
      end else if (addr == PRESC_ADDR) begin
         d.sel = SEL_PRESC;
      end else if (addr == MTIME_LO_ADDR) begin
         d.sel = SEL_MTIME_LO;
      end else if (addr == MTIME_HI_ADDR) begin
         d.sel = SEL_MTIME_HI;
      end else if (int'(msip_off) < 4 * num_harts) begin
         d.sel  = SEL_MSIP;
         d.hart = msip_off[2 +: HART_W];
      end else if (int'(cmp_off) < 8 * num_harts) begin
         d.sel  = cmp_off[2] ? SEL_CMP_HI : SEL_CMP_LO;
         d.hart = cmp_off[3 +: HART_W];
      end
      return d;
   endfunction

endpackage

// File: rtl/clint_cmp_chan.sv
// One per-hart channel: mtimecmp, msip and the registered timer/software interrupt lines.
// The compare uses this cycle's mtime and mtimecmp, so timer_irq trails the condition by one clock.
module clint_cmp_chan
   import clint_pkg::*;
#(
   parameter int RSZ = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [2*RSZ-1:0]   mtime_i,
   input  logic               cmp_lo_we_i,
   input  logic               cmp_hi_we_i,
   input  logic               msip_we_i,
   input  logic [RSZ-1:0]     wr_data_i,
   output logic [2*RSZ-1:0]   mtimecmp_o,
   output logic               timer_irq_o,
   output logic               sw_irq_o
);

   logic [2*RSZ-1:0] mtimecmp_q, mtimecmp_d;
   logic             msip_q, msip_d;
   logic             timer_irq_q, timer_irq_d;

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (cmp_lo_we_i) mtimecmp_d[RSZ-1:0]     = wr_data_i;
      if (cmp_hi_we_i) mtimecmp_d[2*RSZ-1:RSZ] = wr_data_i;
      if (msip_we_i)   msip_d                  = wr_data_i[0];
      timer_irq_d = (mtime_i >= mtimecmp_q);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: mtimecmp resets to all ones (not zero) so no hart sees a timer interrupt out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtimecmp_q  <= '1;
         msip_q      <= 1'b0;
         timer_irq_q <= 1'b0;
      end else begin
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign mtimecmp_o  = mtimecmp_q;
   assign timer_irq_o = timer_irq_q;
   assign sw_irq_o    = msip_q;

endmodule

// File: rtl/clint_timer.sv
// CLINT-style machine timer and software-interrupt controller for 1..8 harts.
// Holds the prescaler, mtime, the coherent-read hi shadow and the registered read port.
module clint_timer
   import clint_pkg::*;
#(
   parameter int NUM_HARTS = 1,
   parameter int RSZ       = 32,
   parameter int PRESC_W   = 8
) (
   input  logic                  clk_in,
   input  logic                  reset_n_in,
   input  logic                  mmr_wr,
   input  logic                  mmr_rd,
   input  logic [15:0]           mmr_addr,
   input  logic [RSZ-1:0]        mmr_wr_data,
   output logic [RSZ-1:0]        mmr_rd_data,
   output logic                  mmr_rd_valid,
   input  logic                  time_en,
   output logic [NUM_HARTS-1:0]  timer_irq,
   output logic [NUM_HARTS-1:0]  sw_irq,
   output logic [2*RSZ-1:0]      mtime
);

   reg_dec_t dec;

   logic wr_presc, wr_mtime_lo, wr_mtime_hi;
   logic rd_mtime_lo, rd_mtime_hi;
   logic tick;

   logic [PRESC_W-1:0] prescale_q, prescale_d;
   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [2*RSZ-1:0]   mtime_q, mtime_d;
   logic [RSZ-1:0]     hi_shadow_q, hi_shadow_d;
   logic               lo_rd_flag_q, lo_rd_flag_d;
   logic [RSZ-1:0]     rd_data_q, rd_data_d;
   logic               rd_valid_q;
   logic [RSZ-1:0]     rd_mux;

   logic [2*RSZ-1:0]     cmp_val [NUM_HARTS];
   logic [NUM_HARTS-1:0] timer_irq_w;
   logic [NUM_HARTS-1:0] sw_irq_w;

   assign dec         = decode_addr(mmr_addr, NUM_HARTS);
   assign wr_presc    = mmr_wr && (dec.sel == SEL_PRESC);
   assign wr_mtime_lo = mmr_wr && (dec.sel == SEL_MTIME_LO);
   assign wr_mtime_hi = mmr_wr && (dec.sel == SEL_MTIME_HI);
   assign rd_mtime_lo = mmr_rd && (dec.sel == SEL_MTIME_LO);
   assign rd_mtime_hi = mmr_rd && (dec.sel == SEL_MTIME_HI);

   assign tick = time_en && (presc_cnt_q == prescale_q);

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_chan
      logic hart_hit;
      assign hart_hit = (dec.hart == HART_W'(h));

      clint_cmp_chan #(
         .RSZ (RSZ)
      ) u_chan (
         .clk_i       (clk_in),
         .rst_ni      (reset_n_in),
         .mtime_i     (mtime_q),
         .cmp_lo_we_i (mmr_wr && hart_hit && (dec.sel == SEL_CMP_LO)),
         .cmp_hi_we_i (mmr_wr && hart_hit && (dec.sel == SEL_CMP_HI)),
         .msip_we_i   (mmr_wr && hart_hit && (dec.sel == SEL_MSIP)),
         .wr_data_i   (mmr_wr_data),
         .mtimecmp_o  (cmp_val[h]),
         .timer_irq_o (timer_irq_w[h]),
         .sw_irq_o    (sw_irq_w[h])
      );
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      prescale_d  = prescale_q;
      presc_cnt_d = presc_cnt_q;
      mtime_d     = mtime_q;

      if (wr_presc) begin
         prescale_d  = mmr_wr_data[PRESC_W-1:0];
         presc_cnt_d = '0;
      end else if (time_en) begin
         presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
      end

      // A software write to either half pre-empts the tick increment for that cycle.
      if (wr_mtime_lo) begin
         mtime_d[RSZ-1:0] = mmr_wr_data;
      end else if (wr_mtime_hi) begin
         mtime_d[2*RSZ-1:RSZ] = mmr_wr_data;
      end else if (tick) begin
         mtime_d = mtime_q + (2*RSZ)'(1);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (dec.sel)
         SEL_MSIP: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (int'(dec.hart) == h) rd_mux = RSZ'(sw_irq_w[h]);
         end
         SEL_CMP_LO: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (int'(dec.hart) == h) rd_mux = cmp_val[h][RSZ-1:0];
         end
         SEL_CMP_HI: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (int'(dec.hart) == h) rd_mux = cmp_val[h][2*RSZ-1:RSZ];
         end
         SEL_PRESC:    rd_mux = RSZ'(prescale_q);
         SEL_MTIME_LO: rd_mux = mtime_q[RSZ-1:0];
         SEL_MTIME_HI: rd_mux = lo_rd_flag_q ? hi_shadow_q : mtime_q[2*RSZ-1:RSZ];
         default:      rd_mux = '0;
      endcase
   end

   // Hi half is frozen at the lo read so a lo/hi pair never straddles a carry.
   always_comb begin
      hi_shadow_d  = hi_shadow_q;
      lo_rd_flag_d = lo_rd_flag_q;
      rd_data_d    = rd_data_q;
      if (mmr_rd) rd_data_d = rd_mux;
      if (rd_mtime_lo) begin
         hi_shadow_d  = mtime_q[2*RSZ-1:RSZ];
         lo_rd_flag_d = 1'b1;
      end
      if (rd_mtime_hi)                lo_rd_flag_d = 1'b0;
      if (wr_mtime_lo || wr_mtime_hi) lo_rd_flag_d = 1'b0;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         prescale_q   <= '0;
         presc_cnt_q  <= '0;
         mtime_q      <= '0;
         hi_shadow_q  <= '0;
         lo_rd_flag_q <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         prescale_q   <= prescale_d;
         presc_cnt_q  <= presc_cnt_d;
         mtime_q      <= mtime_d;
         hi_shadow_q  <= hi_shadow_d;
         lo_rd_flag_q <= lo_rd_flag_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= mmr_rd;
      end
   end

   assign mmr_rd_data  = rd_data_q;
   assign mmr_rd_valid = rd_valid_q;
   assign mtime        = mtime_q;
   assign timer_irq    = timer_irq_w;
   assign sw_irq       = sw_irq_w;

endmodule
